// File: rtl/id_exe_pipe.sv
// ID->EXE pipeline register with RAW-hazard interlock and a saturating stall counter.
// Build option: define FORWARDING_EN for load-use-only interlock (EXE forwarding present);
// leave it undefined for a full interlock against the EXE and MEM stages.
module id_exe_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic [3:0]  src1_ID,
  input  logic [3:0]  src2_ID,
  input  logic [3:0]  ST_src_ID,
  input  logic        use_src2_ID,
  input  logic [3:0]  dest_ID,
  input  logic        WB_EN_ID,
  input  logic        MEM_R_EN_ID,
  input  logic        MEM_W_EN_ID,
  input  logic [3:0]  EXE_CMD_ID,
  input  logic [31:0] val1_ID,
  input  logic [31:0] val2_ID,
  input  logic [31:0] ST_val_ID,
  input  logic [3:0]  dest_MEM,
  input  logic        WB_EN_MEM,
  output logic [3:0]  src1_EXE,
  output logic [3:0]  src2_EXE,
  output logic [3:0]  ST_src_EXE,
  output logic [3:0]  dest_EXE,
  output logic        WB_EN_EXE,
  output logic        MEM_R_EN_EXE,
  output logic        MEM_W_EN_EXE,
  output logic [3:0]  EXE_CMD_EXE,
  output logic [31:0] val1_EXE,
  output logic [31:0] val2_EXE,
  output logic [31:0] ST_val_EXE,
  output logic        hazard_stall,
  output logic [15:0] stall_count
);

  logic hazard;

  // True when the ID instruction reads register r as an operand.
  function automatic logic id_uses(input logic [3:0] r);
    return (r == src1_ID) || (use_src2_ID && (r == src2_ID)) ||
           (MEM_W_EN_ID && (r == ST_src_ID));
  endfunction

  // Hazard detection; WB is never checked since the register file writes before it reads.
`ifdef FORWARDING_EN
  logic unused_mem;
  assign unused_mem = ^{dest_MEM, WB_EN_MEM};

  always_comb begin
    hazard = WB_EN_EXE & MEM_R_EN_EXE & id_uses(dest_EXE);
  end
`else
  always_comb begin
    hazard = (WB_EN_EXE & id_uses(dest_EXE)) | (WB_EN_MEM & id_uses(dest_MEM));
  end
`endif

  assign hazard_stall = hazard & ~flush & ~freeze;

  // Pipeline register: freeze holds, flush/hazard inject a bubble, otherwise capture ID.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src1_EXE     <= '0;
      src2_EXE     <= '0;
      ST_src_EXE   <= '0;
      dest_EXE     <= '0;
      WB_EN_EXE    <= 1'b0;
      MEM_R_EN_EXE <= 1'b0;
      MEM_W_EN_EXE <= 1'b0;
      EXE_CMD_EXE  <= '0;
      val1_EXE     <= '0;
      val2_EXE     <= '0;
      ST_val_EXE   <= '0;
    end else if (!freeze) begin
      if (flush || hazard) begin
        src1_EXE     <= '0;
        src2_EXE     <= '0;
        ST_src_EXE   <= '0;
        dest_EXE     <= '0;
        WB_EN_EXE    <= 1'b0;
        MEM_R_EN_EXE <= 1'b0;
        MEM_W_EN_EXE <= 1'b0;
        EXE_CMD_EXE  <= '0;
        val1_EXE     <= '0;
        val2_EXE     <= '0;
        ST_val_EXE   <= '0;
      end else begin
        src1_EXE     <= src1_ID;
        src2_EXE     <= src2_ID;
        ST_src_EXE   <= ST_src_ID;
        dest_EXE     <= dest_ID;
        WB_EN_EXE    <= WB_EN_ID;
        MEM_R_EN_EXE <= MEM_R_EN_ID;
        MEM_W_EN_EXE <= MEM_W_EN_ID;
        EXE_CMD_EXE  <= EXE_CMD_ID;
        val1_EXE     <= val1_ID;
        val2_EXE     <= val2_ID;
        ST_val_EXE   <= ST_val_ID;
      end
    end
  end

  // Stall-cycle counter: counts interlock bubbles only, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (!freeze && !flush && hazard && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: doc/id_exe_pipe.md
# id_exe_pipe

ID→EXE pipeline register with an integrated RAW-hazard interlock for the 5-stage pipelined MIPS core. It captures decoded operands and control from ID and presents them to the EXE stage, where they feed the EXE operand-forwarding logic (src1/src2/ST_src against dest_MEM/dest_WB). It detects hazards that forwarding cannot resolve and inserts bubbles. It also holds IF/ID via `hazard_stall` and keeps a saturating stall-cycle counter for performance debug.

## Interface
- No parameters. Register index width is fixed at 4 bits and data width at 32 bits.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `freeze` in 1: global memory stall; holds every register.
- `flush` in 1: branch taken; kills the ID instruction.
- `src1_ID`, `src2_ID`, `ST_src_ID` in 4 each: ID source register indices.
- `use_src2_ID` in 1: src2 is a register operand, not an immediate.
- `dest_ID` in 4: destination register index.
- `WB_EN_ID`, `MEM_R_EN_ID`, `MEM_W_EN_ID` in 1 each: ID control bits.
- `EXE_CMD_ID` in 4: ALU command.
- `val1_ID`, `val2_ID`, `ST_val_ID` in 32 each: register-file and immediate values.
- `dest_MEM` in 4, `WB_EN_MEM` in 1: MEM stage destination. Used only without forwarding.
- `src1_EXE`, `src2_EXE`, `ST_src_EXE`, `dest_EXE` out 4 each: registered.
- `WB_EN_EXE`, `MEM_R_EN_EXE`, `MEM_W_EN_EXE` out 1 each: registered.
- `EXE_CMD_EXE` out 4: registered.
- `val1_EXE`, `val2_EXE`, `ST_val_EXE` out 32 each: registered.
- `hazard_stall` out 1: combinational; holds PC and IF/ID when high.
- `stall_count` out 16: registered, saturating.

## Operation
- Hazard term `H`. `ID_uses(r)` is true when any of the following holds:
  - `r == src1_ID`;
  - `use_src2_ID` and `r == src2_ID`;
  - `MEM_W_EN_ID` and `r == ST_src_ID`.
- With forwarding: `H = WB_EN_EXE & MEM_R_EN_EXE & ID_uses(dest_EXE)`. This covers load-use only.
- Without forwarding: `H = (WB_EN_EXE & ID_uses(dest_EXE)) | (WB_EN_MEM & ID_uses(dest_MEM))`.
- The WB stage is never checked, because the register file writes before it reads within a cycle.
- Register 0 is not special-cased; ID must clear `WB_EN_ID` for writes to r0.
- `hazard_stall = H & ~flush & ~freeze`.
- Per-edge priority, highest first:
  1. `freeze`: every register, including `stall_count`, holds.
  2. `flush`: load a bubble.
  3. `H`: load a bubble and increment `stall_count`.
  4. Otherwise, load every `*_ID` input into its `*_EXE` register.
- Bubble: `WB_EN`, `MEM_R_EN`, `MEM_W_EN` = 0; `EXE_CMD` = 0; all indices = 0; all values = 0.
- Because `WB_EN_EXE=0` on a bubble, a bubble can never trigger forwarding or the interlock.
- `stall_count` saturates at 16'hFFFF and never wraps.

## Timing
- Reset (`rst`=0, asynchronous): every registered output is 0, so the pipeline holds a bubble. `hazard_stall`=0 because all enables are 0.
- Latency: an ID instruction appears on the `*_EXE` outputs one cycle after capture.
- A load followed immediately by a dependent instruction gives exactly 1 stall cycle with forwarding. The dependent instruction reaches EXE 2 cycles after the load, and forwarding serves it from MEM/WB.
- Without forwarding, a back-to-back dependent pair stalls for 2 cycles: first EXE match, then MEM match.
- `hazard_stall` is combinational within the cycle and is valid before the same edge on which the bubble is inserted.
- A flush in the same cycle as H produces one bubble, `hazard_stall`=0, and no count.
- Reset asserted mid-stall: outputs clear immediately and the stall ends.

## Configuration
- `FORWARDING_EN` defined: load-use interlock only. `dest_MEM` and `WB_EN_MEM` are ignored.
- `FORWARDING_EN` undefined: full RAW interlock against EXE and MEM. The EXE forwarding selects must then be tied to 0.
- The port list is identical in both builds.

## Test plan
- Reset: drive `rst`=0 mid-run -> all outputs 0 asynchronously, `stall_count`=0.
- Load-use, forwarding build: EXE holds `MEM_R_EN`=1, `WB_EN`=1, `dest`=5; ID has `src1_ID`=5 -> `hazard_stall`=1 for 1 cycle, one bubble inserted, then the instruction passes; `stall_count`=1.
- Store dependency: EXE load `dest`=3; ID store with `ST_src_ID`=3, `src1_ID`=1, `use_src2_ID`=0 -> stall 1 cycle. With `MEM_W_EN_ID`=0 instead -> no stall.
- Flush+hazard: H true and `flush`=1 in the same cycle -> bubble, `hazard_stall`=0, count unchanged.
- Freeze: `freeze`=1 for 3 cycles with `val1_ID` changing -> `val1_EXE` holds its old value, `stall_count` holds.
- No-forwarding build: ALU op in EXE writes r7 (`WB_EN`=1, `MEM_R_EN`=0); ID reads `src2_ID`=7 with `use_src2_ID`=1 -> 2 stall cycles; `stall_count` preset near 16'hFFFF saturates at 16'hFFFF.
